// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: FIFO of shift commands feeding an external combinational shifter, with a registered valid/ready result stage.
//   cmd_*   : upstream command push (valid/ready), operand, shift amount, arith/left flags
//   shift_* : head-of-queue drive to the shifter (all zero while empty); shift_out_i is its result
//   res_*   : downstream registered result (valid/ready)
//   count_o : commands queued, not counting the one held in the result register
module shift_cmd_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
  parameter int DEPTH       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]    cmd_data_i,
  input  logic [SHAMT_WIDTH-1:0]   cmd_shamt_i,
  input  logic                     cmd_arith_i,
  input  logic                     cmd_left_i,
  output logic [DATA_WIDTH-1:0]    shift_in_o,
  output logic [SHAMT_WIDTH-1:0]   shift_amount_o,
  output logic                     arith_shift_o,
  output logic                     left_shift_o,
  input  logic [DATA_WIDTH-1:0]    shift_out_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [DATA_WIDTH-1:0]    res_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   arith;
    logic                   left;
  } cmd_t;
  cmd_t                  mem_q [DEPTH];
  cmd_t                  head;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  push, pop, empty;
  // ready depends only on the occupancy register, never on res_ready_i
  assign cmd_ready_o = count_q < CW'(DEPTH);
  always_comb begin
    empty       = count_q == '0;
    push        = cmd_valid_i && cmd_ready_o;
    pop         = !empty && (!res_valid_q || res_ready_i);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    res_valid_d = pop || (res_valid_q && !res_ready_i);
    res_data_d  = pop ? shift_out_i : res_data_q;
    head        = empty ? '0 : mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end
  // storage is not reset: entries are only visible once counted
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_data_i, cmd_shamt_i, cmd_arith_i, cmd_left_i};
  end
  assign shift_in_o     = head.data;
  assign shift_amount_o = head.shamt;
  assign arith_shift_o  = head.arith;
  assign left_shift_o   = head.left;
  assign res_valid_o    = res_valid_q;
  assign res_data_o     = res_data_q;
  assign count_o        = count_q;
endmodule
